attex_bus_fabric: RTL and testbench

ATTEX_BUS_FABRIC -- requirements
Module: attex_bus_fabric

---
 rtl/attex_bus_fabric.sv | 169 ++++++++++++++++
 tb/tb_attex_bus_fabric.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/attex_bus_fabric.sv
// attex_bus_fabric: 68k-style bus fabric. It decodes the CPU address into one-hot
// slave selects, steers read data and acknowledges back to the CPU, and raises a
// bus error for unmapped addresses.
// Optional build macro ATTEX_BUS_TIMEOUT_EN adds an ACTIVE-state watchdog. The
// watchdog raises a bus error after TIMEOUT_CYCLES cycles without an acknowledge.
module attex_bus_fabric #(
    parameter int unsigned                 NUM_SLAVES     = 5,
    parameter logic [8*NUM_SLAVES-1:0]     REGION_BASE    = {8'hD0, 8'h00, 8'h32, 8'h31, 8'h30},
    parameter logic [8*NUM_SLAVES-1:0]     REGION_MASK    = {8'hF0, 8'hC0, 8'hFF, 8'hFF, 8'hFF},
    parameter int unsigned                 TIMEOUT_CYCLES = 1023
) (
    input  logic                       clk30,
    input  logic                       reset,
    input  logic                       as,
    input  logic                       uds,
    input  logic                       lds,
    input  logic [23:1]                addr,
    input  logic                       iack,
    input  logic [15:0]                iack_dout,
    input  logic [16*NUM_SLAVES-1:0]   slave_dout,
    input  logic [NUM_SLAVES-1:0]      slave_ack,
    output logic [NUM_SLAVES-1:0]      cs,
    output logic [NUM_SLAVES-1:0]      cs_rise,
    output logic [15:0]                data_in,
    output logic                       bus_ack,
    output logic                       bus_err,
    output logic [23:0]                err_addr
);

    localparam int unsigned SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    // Reject illegal configurations at elaboration
    if (NUM_SLAVES < 1 || NUM_SLAVES > 8) begin : g_bad_num_slaves
        $error("attex_bus_fabric: NUM_SLAVES must be 1..8");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("attex_bus_fabric: TIMEOUT_CYCLES must be 2..65535");
    end

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE, ERR} state_t;

    state_t                  state;
    logic [SEL_W-1:0]        sel;
    logic [SEL_W-1:0]        hit_idx;
    logic [NUM_SLAVES-1:0]   match;
    logic [NUM_SLAVES-1:0]   cs_q;
    logic [15:0]             data_q;
    logic [15:0]             dout_arr [NUM_SLAVES];
    logic                    hit;
    logic                    start;
    logic                    sel_ack;
    logic [15:0]             sel_dout;
    logic                    expired;

    // Per-slave region match and read-data unpacking
    for (genvar i = 0; i < int'(NUM_SLAVES); i++) begin : g_slave
        assign match[i]    = as && ((addr[23:16] & REGION_MASK[8*i +: 8]) == REGION_BASE[8*i +: 8]);
        assign dout_arr[i] = slave_dout[16*i +: 16];
    end

    // Lowest matching index wins
    always_comb begin
        hit_idx = '0;
        for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
            if (match[i]) hit_idx = SEL_W'(i);
        end
    end

    assign hit      = |match;
    assign cs       = match & (~match + NUM_SLAVES'(1));
    assign cs_rise  = cs & ~cs_q;
    assign start    = as && (uds || lds);
    assign sel_ack  = slave_ack[sel];
    assign sel_dout = dout_arr[sel];
    assign bus_err  = (state == ERR);

`ifdef ATTEX_BUS_TIMEOUT_EN
    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [15:0] to_cnt;
    logic [15:0] to_inc;

    assign to_inc  = (to_cnt == 16'hFFFF) ? to_cnt : to_cnt + 16'd1;
    assign expired = (to_inc >= TO_LIMIT);

    // Watchdog: cleared while idle, saturating count of ACTIVE cycles
    always_ff @(posedge clk30) begin
        if (reset || state == IDLE) begin
            to_cnt <= '0;
        end else if (state == ACTIVE) begin
            to_cnt <= to_inc;
        end
    end
`else
    assign expired = 1'b0;
`endif

    // Previous-cycle select, for edge detection
    always_ff @(posedge clk30) begin
        if (reset) cs_q <= '0;
        else       cs_q <= cs;
    end

    // Bus cycle FSM with latched select, read data and error address
    always_ff @(posedge clk30) begin
        if (reset) begin
            state    <= IDLE;
            sel      <= '0;
            data_q   <= '0;
            err_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (iack) begin
                            state  <= DONE;
                            data_q <= iack_dout;
                        end else if (hit) begin
                            state <= ACTIVE;
                            sel   <= hit_idx;
                        end else begin
                            state    <= ERR;
                            err_addr <= {addr, 1'b0};
                        end
                    end
                end
                ACTIVE: begin
                    if (!as) begin
                        state <= IDLE;
                    end else if (sel_ack) begin
                        state  <= DONE;
                        data_q <= sel_dout;
                    end else if (expired) begin
                        state    <= ERR;
                        err_addr <= {addr, 1'b0};
                    end
                end
                DONE, ERR: begin
                    if (!as) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // CPU-facing acknowledge and read data; same-cycle for iack and slave acks
    always_comb begin
        bus_ack = 1'b0;
        data_in = 16'h0000;
        case (state)
            IDLE: begin
                if (start && iack) begin
                    bus_ack = 1'b1;
                    data_in = iack_dout;
                end
            end
            ACTIVE: begin
                bus_ack = as && sel_ack;
                data_in = sel_dout;
            end
            DONE: begin
                bus_ack = 1'b1;
                data_in = data_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_attex_bus_fabric.sv
// Directed bench for attex_bus_fabric with a read-data scoreboard.
module tb_attex_bus_fabric;

    localparam int unsigned NS = 5;

    logic              clk30 = 1'b0;
    logic              reset;
    logic              as;
    logic              uds;
    logic              lds;
    logic [23:1]       addr;
    logic              iack;
    logic [15:0]       iack_dout;
    logic [16*NS-1:0]  slave_dout;
    logic [NS-1:0]     slave_ack;
    logic [NS-1:0]     cs;
    logic [NS-1:0]     cs_rise;
    logic [15:0]       data_in;
    logic              bus_ack;
    logic              bus_err;
    logic [23:0]       err_addr;

    int checks = 0;
    int errors = 0;
    int seen_err;

    typedef struct {
        string       tag;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];

    attex_bus_fabric #(
        .NUM_SLAVES     (NS),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk30      (clk30),
        .reset      (reset),
        .as         (as),
        .uds        (uds),
        .lds        (lds),
        .addr       (addr),
        .iack       (iack),
        .iack_dout  (iack_dout),
        .slave_dout (slave_dout),
        .slave_ack  (slave_ack),
        .cs         (cs),
        .cs_rise    (cs_rise),
        .data_in    (data_in),
        .bus_ack    (bus_ack),
        .bus_err    (bus_err),
        .err_addr   (err_addr)
    );

    always #5 clk30 = ~clk30;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [15:0] d);
        exp_t e;
        e.tag  = tag;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic sb_pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_ack"}, 32'(bus_ack), 32'd1);
            chk({e.tag, "_data"}, 32'(data_in), 32'(e.data));
        end
    endtask

    task automatic next();
        @(posedge clk30);
        #1;
    endtask

    task automatic settle();
        @(negedge clk30);
    endtask

    task automatic set_dout(input int i, input logic [15:0] v);
        slave_dout[16*i +: 16] = v;
    endtask

    task automatic start(input logic [23:0] a, input logic ia);
        as   = 1'b1;
        uds  = 1'b1;
        lds  = 1'b1;
        addr = a[23:1];
        iack = ia;
    endtask

    task automatic release_bus();
        as        = 1'b0;
        uds       = 1'b0;
        lds       = 1'b0;
        iack      = 1'b0;
        slave_ack = '0;
    endtask

    // One cycle with the strobe dropped so the FSM returns to IDLE
    task automatic finish_cycle();
        next();
        release_bus();
        settle();
    endtask

    initial begin
        reset = 1'b1; as = 1'b0; uds = 1'b0; lds = 1'b0; addr = '0; iack = 1'b0;
        iack_dout = '0; slave_dout = '0; slave_ack = '0; seen_err = 0;
        next(); next();
        reset = 1'b0;
        settle();
        chk("rst_bus_ack", 32'(bus_ack), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_data_in", 32'(data_in), 32'h0);
        chk("rst_err_addr", 32'(err_addr), 32'h0);
        chk("rst_cs", 32'(cs), 32'h0);
        chk("rst_cs_rise", 32'(cs_rise), 32'h0);

        // Read 0x300010, slave 0 acks three cycles after start
        next(); start(24'h300010, 1'b0); set_dout(0, 16'hBEEF); sb_push("rd300010", 16'hBEEF);
        settle();
        chk("t1_cs", 32'(cs), 32'h01);
        chk("t1_cs_rise", 32'(cs_rise), 32'h01);
        chk("t1_ack_c0", 32'(bus_ack), 32'd0);
        for (int c = 1; c <= 2; c++) begin
            next(); settle();
            chk("t1_ack_wait", 32'(bus_ack), 32'd0);
        end
        next(); slave_ack[0] = 1'b1; settle();
        sb_pop_check();
        next(); slave_ack[0] = 1'b0; set_dout(0, 16'h1234); settle();
        chk("t1_hold_ack", 32'(bus_ack), 32'd1);
        chk("t1_hold_data", 32'(data_in), 32'hBEEF);
        finish_cycle();
        next(); settle();
        chk("t1_idle_ack", 32'(bus_ack), 32'd0);
        chk("t1_idle_data", 32'(data_in), 32'h0);

        // 0x310000: single-cycle cs_rise, then abort with a late ack
        next(); start(24'h310000, 1'b0); settle();
        chk("t2_cs", 32'(cs), 32'h02);
        chk("t2_cs_rise", 32'(cs_rise), 32'h02);
        next(); settle();
        chk("t2_cs_hold", 32'(cs), 32'h02);
        chk("t2_cs_rise_off", 32'(cs_rise), 32'h00);
        next(); release_bus(); slave_ack[1] = 1'b1; settle();
        chk("t2_abort_ack", 32'(bus_ack), 32'd0);
        next(); slave_ack = '0; settle();
        chk("t2_idle_ack", 32'(bus_ack), 32'd0);
        chk("t2_idle_err", 32'(bus_err), 32'd0);
        chk("t2_idle_data", 32'(data_in), 32'h0);

        // 0x200000 decodes to slave 3, immediate ack
        next(); start(24'h200000, 1'b0); set_dout(3, 16'h3333); sb_push("rd200000", 16'h3333);
        settle();
        chk("t3_cs", 32'(cs), 32'h08);
        next(); slave_ack[3] = 1'b1; settle();
        sb_pop_check();
        finish_cycle();

        // 0x300000 matches slaves 0 and 3; slave 0 wins
        next(); start(24'h300000, 1'b0); settle();
        chk("t4_cs_prio", 32'(cs), 32'h01);
        finish_cycle();

        // Unmapped 0x600000 raises a bus error
        next(); start(24'h600000, 1'b0); uds = 1'b0; settle();
        chk("t5_cs", 32'(cs), 32'h00);
        chk("t5_err_c0", 32'(bus_err), 32'd0);
        next(); settle();
        chk("t5_err", 32'(bus_err), 32'd1);
        chk("t5_err_addr", 32'(err_addr), 32'h600000);
        chk("t5_err_ack", 32'(bus_ack), 32'd0);
        chk("t5_err_data", 32'(data_in), 32'h0);
        next(); settle();
        chk("t5_err_hold", 32'(bus_err), 32'd1);
        finish_cycle();
        next(); settle();
        chk("t5_err_clear", 32'(bus_err), 32'd0);
        chk("t5_err_addr_kept", 32'(err_addr), 32'h600000);

        // Address strobe without byte strobes starts nothing
        next(); start(24'h600000, 1'b0); uds = 1'b0; lds = 1'b0; settle();
        next(); settle();
        chk("t5b_no_strobe_err", 32'(bus_err), 32'd0);
        finish_cycle();

        // Interrupt acknowledge overrides decode and ignores slave_ack
        next(); start(24'h300000, 1'b1); iack_dout = 16'h0064; slave_ack[0] = 1'b1;
        set_dout(0, 16'hDEAD); sb_push("iack", 16'h0064);
        settle();
        chk("t6_cs", 32'(cs), 32'h01);
        sb_pop_check();
        next(); iack_dout = 16'hFFFF; settle();
        chk("t6_hold_ack", 32'(bus_ack), 32'd1);
        chk("t6_hold_data", 32'(data_in), 32'h0064);
        finish_cycle();

`ifdef ATTEX_BUS_TIMEOUT_EN
        // Watchdog expires after four ACTIVE cycles without ack
        next(); start(24'hD00000, 1'b0); settle();
        chk("t7_cs", 32'(cs), 32'h10);
        for (int c = 1; c <= 4; c++) begin
            next(); settle();
            chk("t7_err_wait", 32'(bus_err), 32'd0);
        end
        next(); settle();
        chk("t7_timeout_err", 32'(bus_err), 32'd1);
        chk("t7_timeout_addr", 32'(err_addr), 32'hD00000);
        chk("t7_timeout_ack", 32'(bus_ack), 32'd0);
        finish_cycle();
        // Ack on the fourth ACTIVE cycle beats expiry
        next(); start(24'hD00000, 1'b0); set_dout(4, 16'h4444); sb_push("to_race", 16'h4444);
        settle();
        for (int c = 1; c <= 3; c++) begin
            next(); settle();
            chk("t7b_err_wait", 32'(bus_err), 32'd0);
        end
        next(); slave_ack[4] = 1'b1; settle();
        sb_pop_check();
        next(); slave_ack = '0; settle();
        chk("t7b_no_err", 32'(bus_err), 32'd0);
        chk("t7b_done_ack", 32'(bus_ack), 32'd1);
        finish_cycle();
`else
        // Without the watchdog an unacked access waits indefinitely
        next(); start(24'hD00000, 1'b0); set_dout(4, 16'h4444); settle();
        chk("t7_cs", 32'(cs), 32'h10);
        for (int c = 1; c <= 10000; c++) begin
            next(); settle();
            if (bus_err) seen_err++;
        end
        chk("t7_no_timeout", 32'(seen_err), 32'd0);
        chk("t7_still_waiting", 32'(bus_ack), 32'd0);
        sb_push("late_ack", 16'h4444);
        next(); slave_ack[4] = 1'b1; settle();
        sb_pop_check();
        finish_cycle();
`endif

        // Reset while ACTIVE returns to IDLE and clears the edge detector
        next(); start(24'h310000, 1'b0); settle();
        next(); reset = 1'b1; settle();
        next(); reset = 1'b0; slave_ack[1] = 1'b1; settle();
        chk("t8_rst_ack", 32'(bus_ack), 32'd0);
        chk("t8_rst_err", 32'(bus_err), 32'd0);
        chk("t8_rst_data", 32'(data_in), 32'h0);
        chk("t8_rst_cs_rise", 32'(cs_rise), 32'h02);
        finish_cycle();
        next(); start(24'h320000, 1'b0); set_dout(2, 16'h2222); sb_push("post_rst", 16'h2222);
        settle();
        chk("t8_cs", 32'(cs), 32'h04);
        next(); slave_ack[2] = 1'b1; settle();
        sb_pop_check();
        finish_cycle();
        next(); settle();
        chk("t8_idle_ack", 32'(bus_ack), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
